cfg_bus_master: RTL and testbench
=================================

CFG_BUS_MASTER -- requirements
Module: cfg_bus_master

Interface
REQ-001 SHALL take parameter RD_LATENCY, default 0: cycles between the end of the ISSUE cycle and the cfg_rdata sample point (0 = sampled at end of ISSUE).
REQ-002 SHALL take parameter FIFO_DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-003 SHALL take widths MSB and MSB_REGS_ADDRESS from the shared sync parameter include.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  host command present.
REQ-007 cmd_ready  out  1  FIFO can accept a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  MSB_REGS_ADDRESS+1  target register address.
REQ-010 cmd_wdata  in  MSB+1  write data; ignored for reads.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  host accepts the response.
REQ-013 rsp_write  out  1  echo of the completed command type.
REQ-014 rsp_rdata  out  MSB+1  read data; 0 for write responses.
REQ-015 cfg_we  out  1  register-bank write strobe.
REQ-016 cfg_addr  out  MSB_REGS_ADDRESS+1  register-bank address.
REQ-017 cfg_data_in  out  MSB+1  register-bank write data.
REQ-018 cfg_rdata  in  MSB+1  read-back mux of the bank's cfg_data_out outputs.
REQ-019 busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-020 A command SHALL be accepted when cmd_valid && cmd_ready; cmd_ready SHALL equal !fifo_full, with no same-cycle pass-through when full.
REQ-021 The FSM SHALL have states IDLE, ISSUE, RD_WAIT and RESP.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry, register it into cfg_addr/cfg_data_in, and enter ISSUE.
REQ-023 In ISSUE, cfg_we SHALL equal the command's write bit for exactly one cycle.
REQ-024 On leaving ISSUE, the FSM SHALL go to RESP if the command is a write or RD_LATENCY==0, and to RD_WAIT otherwise.
REQ-025 RD_WAIT SHALL count RD_LATENCY cycles; the FSM SHALL then go to RESP.
REQ-026 cfg_rdata SHALL be captured into rsp_rdata on the final ISSUE/RD_WAIT cycle of a read.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_write SHALL be stable until rsp_ready; the FSM SHALL then return to IDLE.
REQ-028 Timing for a command accepted in cycle N with the FSM idle: ISSUE in N+2, rsp_valid from N+3+(read ? RD_LATENCY : 0).
REQ-029 cfg_we SHALL never be asserted outside ISSUE.
REQ-030 cfg_addr/cfg_data_in SHALL hold their last values between transactions.
REQ-031 cfg_addr SHALL stay stable from ISSUE through the sample cycle.
REQ-032 Commands SHALL complete strictly in acceptance order, one outstanding on the cfg bus at a time.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; push and pop in the same cycle SHALL leave the count unchanged.
REQ-034 Commands SHALL keep being accepted into the FIFO while RESP stalls on rsp_ready.

Reset
REQ-035 Asserting rst_n low SHALL immediately clear: FIFO, state=IDLE, cfg_we=0, cfg_addr=0, cfg_data_in=0, rsp_valid=0, rsp_rdata=0, rsp_write=0, busy=0; cmd_ready SHALL be 1 after deassertion.
REQ-036 Reset mid-transaction SHALL discard the in-flight and queued commands, produce no response, and generate no cfg_we pulse.

Structure
REQ-037 MSB, MSB_REGS_ADDRESS and the FSM state encodings SHALL live in the shared sync parameter include/package.
REQ-038 The command FIFO SHALL be a sub-module, cfg_cmd_fifo (storage plus full/empty logic).

Verification
REQ-039 Write 0xA5 to address 3 with rsp_ready=1 -> cfg_we high for exactly 1 cycle in N+2 with cfg_addr=3, cfg_data_in=0xA5; rsp_valid in N+3, rsp_write=1, rsp_rdata=0.
REQ-040 RD_LATENCY=2, read address 5 with cfg_rdata=0x3C -> cfg_we stays 0; rsp_valid in N+5 with rsp_rdata=0x3C.
REQ-041 rsp_ready=0 while pushing 5 commands with FIFO_DEPTH=4 -> 1 command in flight, 4 queued, cmd_ready=0; release rsp_ready -> 5 responses in order.
REQ-042 Back-to-back write then read of the same address -> read returns the written value; exactly one cfg_we pulse is seen.
REQ-043 Assert rst_n low during RD_WAIT with 2 commands queued -> no rsp_valid, no cfg_we; all outputs at reset values; busy=0.
REQ-044 Push on a cycle where the FIFO is full and the FSM pops -> push is refused (cmd_ready=0); count stays FIFO_DEPTH-1 after the pop.

Source files
------------

// File: rtl/cfg_bus_master_pkg.sv
// rtl/cfg_bus_master_pkg.sv - shared widths, command record and FSM encodings for the cfg bus master
package cfg_bus_master_pkg;

    localparam int MSB              = 7;
    localparam int MSB_REGS_ADDRESS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } cfg_state_t;

    typedef struct packed {
        logic                      write;
        logic [MSB_REGS_ADDRESS:0] addr;
        logic [MSB:0]              wdata;
    } cfg_cmd_t;

endpackage

// File: rtl/cfg_cmd_fifo.sv
// rtl/cfg_cmd_fifo.sv - command FIFO; pointers wrap naturally because DEPTH is a power of two
module cfg_cmd_fifo
    import cfg_bus_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  cfg_cmd_t push_data,
    input  logic     pop,
    output cfg_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    cfg_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cfg_bus_master.sv
// rtl/cfg_bus_master.sv - queues host commands and plays them one at a time onto the register-bank bus
module cfg_bus_master
    import cfg_bus_master_pkg::*;
#(
    parameter int RD_LATENCY = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [MSB_REGS_ADDRESS:0] cmd_addr,
    input  logic [MSB:0]              cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [MSB:0]              rsp_rdata,
    output logic                      cfg_we,
    output logic [MSB_REGS_ADDRESS:0] cfg_addr,
    output logic [MSB:0]              cfg_data_in,
    input  logic [MSB:0]              cfg_rdata,
    output logic                      busy
);

    localparam int            CW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    cfg_state_t    state;
    cfg_state_t    state_nxt;
    cfg_cmd_t      push_data;
    cfg_cmd_t      pop_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          capture;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cur_write;
    logic [CW-1:0] cnt;

    assign push_data = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    cfg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign cfg_we    = (state == ST_ISSUE) && cur_write;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = !fifo_empty || (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cur_write || RD_LATENCY == 0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt == LAST) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_inc   = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cfg_addr/cfg_data_in only change on a pop, so they hold between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_addr    <= '0;
            cfg_data_in <= '0;
            cur_write   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            cnt         <= '0;
        end else begin
            if (pop) begin
                cfg_addr    <= pop_data.addr;
                cfg_data_in <= pop_data.wdata;
                cur_write   <= pop_data.write;
            end
            if (capture) begin
                rsp_write <= cur_write;
                rsp_rdata <= cur_write ? '0 : cfg_rdata;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cfg_bus_master.sv
// tb/tb_cfg_bus_master.sv - directed vectors and corner sequences for cfg_bus_master
module tb_cfg_bus_master;
    import cfg_bus_master_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data_in;
    logic [7:0] cfg_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int we_total  = 0;
    int rsp_total = 0;

    logic [7:0] regs [16] = '{5: 8'h3C, default: 8'h00};
    logic       got_w [8];
    logic [7:0] got_d [8];

    always #5 clk = ~clk;

    cfg_bus_master #(
        .RD_LATENCY (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data_in (cfg_data_in),
        .cfg_rdata   (cfg_rdata),
        .busy        (busy)
    );

    // Register bank model
    assign cfg_rdata = regs[cfg_addr];
    always @(posedge clk) begin
        if (cfg_we) begin
            regs[cfg_addr] <= cfg_data_in;
            we_total <= we_total + 1;
        end
        if (rsp_valid && rsp_ready) rsp_total <= rsp_total + 1;
    end

    typedef struct {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        int we_cnt;
        int we_at;
        logic [3:0] issue_addr;
        chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
        drive(v.w, v.a, v.d);
        step();
        cmd_valid = 1'b0;
        k = 1; we_cnt = 0; we_at = 0; issue_addr = '0;
        while (!rsp_valid && k < 20) begin
            if (k == 2) issue_addr = cfg_addr;
            if (cfg_we) begin
                we_cnt++;
                we_at = k;
            end
            step();
            k++;
        end
        chk($sformatf("v%0d_latency", idx), k, v.exp_lat);
        chk($sformatf("v%0d_we_count", idx), we_cnt, v.w);
        if (v.w) chk($sformatf("v%0d_we_cycle", idx), we_at, 2);
        chk($sformatf("v%0d_issue_addr", idx), issue_addr, v.a);
        chk($sformatf("v%0d_rsp_write", idx), rsp_write, v.w);
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_addr_hold", idx), cfg_addr, v.a);
        chk($sformatf("v%0d_we_in_resp", idx), cfg_we, 0);
        step();
        chk($sformatf("v%0d_rsp_done", idx), rsp_valid, 0);
    endtask

    task automatic collect(input int n, input int budget, output int got);
        int c;
        got = 0;
        c = 0;
        while (got < n && c < budget) begin
            if (rsp_valid && rsp_ready) begin
                got_w[got] = rsp_write;
                got_d[got] = rsp_rdata;
                got++;
            end
            step();
            c++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_cfg_we"}, cfg_we, 0);
        chk({tag, "_cfg_addr"}, cfg_addr, 0);
        chk({tag, "_cfg_data_in"}, cfg_data_in, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_write"}, rsp_write, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int w0;
        int r0;
        logic       sw [5];
        logic [3:0] sa [5];
        logic [7:0] sd [5];
        logic       ew [5];
        logic [7:0] ed [5];

        vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 3};
        vecs[1] = '{1'b0, 4'd5,  8'h00, 8'h3C, 5};
        vecs[2] = '{1'b0, 4'd3,  8'h99, 8'hA5, 5};
        vecs[3] = '{1'b1, 4'd15, 8'hFF, 8'h00, 3};
        vecs[4] = '{1'b0, 4'd15, 8'h00, 8'hFF, 5};
        vecs[5] = '{1'b0, 4'd0,  8'h00, 8'h00, 5};
        vecs[6] = '{1'b1, 4'd0,  8'h01, 8'h00, 3};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 8'h01, 5};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Back-to-back write then read of the same address
        w0 = we_total;
        drive(1'b1, 4'd7, 8'h66);
        step();
        drive(1'b0, 4'd7, 8'h00);
        chk("b2b_push2_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        collect(2, 40, got);
        chk("b2b_count", got, 2);
        chk("b2b_r0_write", got_w[0], 1);
        chk("b2b_r0_rdata", got_d[0], 8'h00);
        chk("b2b_r1_write", got_w[1], 0);
        chk("b2b_r1_rdata", got_d[1], 8'h66);
        chk("b2b_we_pulses", we_total - w0, 1);

        // Stall the response while filling the FIFO
        sw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        sa = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd5};
        sd = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
        ew = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ed = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h3C};
        step();
        w0 = we_total;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_push%0d_ready", i), cmd_ready, 1);
            drive(sw[i], sa[i], sd[i]);
            step();
        end
        cmd_valid = 1'b0;
        repeat (3) step();
        chk("stall_full", cmd_ready, 0);
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_busy", busy, 1);
        chk("stall_r0_write", rsp_write, ew[0]);
        chk("stall_r0_rdata", rsp_rdata, ed[0]);
        drive(1'b1, 4'd8, 8'h77);
        rsp_ready = 1'b1;
        chk("full_release_ready", cmd_ready, 0);
        step();
        chk("full_pop_ready", cmd_ready, 0);
        chk("full_pop_rsp_valid", rsp_valid, 0);
        step();
        chk("after_pop_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        collect(4, 60, got);
        chk("stall_rest_count", got, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_r%0d_write", i + 1), got_w[i], ew[i + 1]);
            chk($sformatf("stall_r%0d_rdata", i + 1), got_d[i], ed[i + 1]);
        end
        r0 = rsp_total;
        repeat (10) step();
        chk("stall_no_extra_rsp", rsp_total - r0, 0);
        chk("stall_refused_not_written", regs[8], 8'h00);
        chk("stall_we_pulses", we_total - w0, 2);
        chk("stall_idle_busy", busy, 0);

        // Reset during RD_WAIT with two commands queued
        w0 = we_total;
        r0 = rsp_total;
        drive(1'b0, 4'd5, 8'h00);
        step();
        drive(1'b1, 4'd4, 8'h44);
        step();
        drive(1'b1, 4'd6, 8'h66);
        step();
        cmd_valid = 1'b0;
        chk("rst_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("rst_mid_no_rsp", rsp_total - r0, 0);
        chk("rst_mid_no_we", we_total - w0, 0);
        chk("rst_mid_reg4", regs[4], 8'h00);
        chk("rst_mid_after_busy", busy, 0);
        chk("rst_mid_after_ready", cmd_ready, 1);
        chk("rst_mid_after_addr", cfg_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
